// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared constants and types for the instruction fetch unit
package ifu_pkg;

  localparam int XLEN = 32;
  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic            fault;
  } fetch_entry_t;

  typedef enum logic {
    ISSUE_IDLE = 1'b0,
    ISSUE_REQ  = 1'b1
  } issue_state_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// rtl/ifu_fifo.sv - registered synchronous FIFO with flush; flush beats push
module ifu_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             din,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    empty   = (count == '0);
    full    = (count == CW'(DEPTH));
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    head    = mem[rd_ptr];
  end

  // Storage needs no reset: entries are only visible between the pointers.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/ifu_prefetch.sv
// rtl/ifu_prefetch.sv - AXI4-Lite sequential instruction prefetcher with a credit-limited buffer
module ifu_prefetch
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h8000_0000,
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        ifu_arvalid,
  input  logic        ifu_arready,
  output logic [31:0] ifu_araddr,
  input  logic        ifu_rvalid,
  output logic        ifu_rready,
  input  logic [31:0] ifu_rdata,
  input  logic [1:0]  ifu_rresp,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = CW + 1;

  issue_state_t    state, state_nxt;
  logic [XLEN-1:0] fetch_pc, fetch_pc_nxt;
  logic [XLEN-1:0] resp_pc, resp_pc_nxt;
  logic [XLEN-1:0] araddr_q, araddr_nxt;
  logic [CW-1:0]   inflight, inflight_nxt;
  logic [CW-1:0]   drop_cnt, drop_cnt_nxt;
  logic [CW-1:0]   fifo_count, count_nxt;
  logic            halted, halted_nxt;
  logic            stale_pending, stale_pending_nxt;
  logic            ar_hs, r_beat, push, pop, resp_fault, credit_ok, fifo_empty;
  fetch_entry_t    push_entry, head_entry;

  ifu_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .head  (head_entry),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  // Everything is first resolved to its end-of-cycle value so that the
  // credit check sees this cycle's handshakes, beats, pops and redirect.
  always_comb begin
    ar_hs      = ifu_arvalid && ifu_arready;
    r_beat     = ifu_rvalid;
    resp_fault = (ifu_rresp != RESP_OKAY);
    pop        = inst_valid && inst_ready;
    push       = r_beat && !redirect_valid && (drop_cnt == '0);
    push_entry = '{inst: ifu_rdata, pc: resp_pc, fault: resp_fault};

    inflight_nxt = inflight;
    if (ar_hs && !r_beat)      inflight_nxt = inflight + CW'(1);
    else if (!ar_hs && r_beat) inflight_nxt = inflight - CW'(1);

    count_nxt = fifo_count;
    if (redirect_valid)     count_nxt = '0;
    else if (push && !pop)  count_nxt = fifo_count + CW'(1);
    else if (!push && pop)  count_nxt = fifo_count - CW'(1);

    if (redirect_valid) begin
      fetch_pc_nxt      = word_align(redirect_pc);
      resp_pc_nxt       = word_align(redirect_pc);
      halted_nxt        = 1'b0;
      drop_cnt_nxt      = inflight_nxt;
      stale_pending_nxt = ifu_arvalid && !ifu_arready;
    end else begin
      // A stale request was issued before the redirect and must not advance the new stream.
      fetch_pc_nxt      = (ar_hs && !stale_pending) ? fetch_pc + 32'd4 : fetch_pc;
      resp_pc_nxt       = push ? resp_pc + 32'd4 : resp_pc;
      halted_nxt        = halted || (push && resp_fault);
      drop_cnt_nxt      = drop_cnt;
      if (r_beat && drop_cnt != '0) drop_cnt_nxt = drop_cnt_nxt - CW'(1);
      if (ar_hs && stale_pending)   drop_cnt_nxt = drop_cnt_nxt + CW'(1);
      stale_pending_nxt = stale_pending && !ar_hs;
    end

    credit_ok = !halted_nxt
             && (inflight_nxt < CW'(MAX_OUTSTANDING))
             && ((SW'(inflight_nxt) + SW'(count_nxt)) < SW'(DEPTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ISSUE_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    araddr_nxt = araddr_q;
    case (state)
      ISSUE_IDLE: begin
        if (credit_ok) begin
          state_nxt  = ISSUE_REQ;
          araddr_nxt = fetch_pc_nxt;
        end
      end
      ISSUE_REQ: begin
        if (ifu_arready) begin
          state_nxt  = credit_ok ? ISSUE_REQ : ISSUE_IDLE;
          araddr_nxt = fetch_pc_nxt;
        end
      end
      default: state_nxt = ISSUE_IDLE;
    endcase
  end

  always_comb begin
    ifu_arvalid = (state == ISSUE_REQ);
    ifu_araddr  = araddr_q;
    ifu_rready  = 1'b1;
    inst_valid  = !fifo_empty;
    inst        = fifo_empty ? '0   : head_entry.inst;
    inst_pc     = fifo_empty ? '0   : head_entry.pc;
    inst_fault  = fifo_empty ? 1'b0 : head_entry.fault;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc      <= RESET_PC;
      resp_pc       <= RESET_PC;
      araddr_q      <= RESET_PC;
      inflight      <= '0;
      drop_cnt      <= '0;
      halted        <= 1'b0;
      stale_pending <= 1'b0;
    end else begin
      fetch_pc      <= fetch_pc_nxt;
      resp_pc       <= resp_pc_nxt;
      araddr_q      <= araddr_nxt;
      inflight      <= inflight_nxt;
      drop_cnt      <= drop_cnt_nxt;
      halted        <= halted_nxt;
      stale_pending <= stale_pending_nxt;
    end
  end

endmodule

// File: tb/tb_ifu_prefetch.sv
// tb/tb_ifu_prefetch.sv - directed self-checking bench for ifu_prefetch
module tb_ifu_prefetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid, ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
  logic        inst_valid, inst_ready, inst_fault;
  logic [31:0] redirect_pc, ifu_araddr, ifu_rdata, inst, inst_pc;
  logic [1:0]  ifu_rresp;

  always #5 clk = ~clk;

  ifu_prefetch #(
    .RESET_PC        (32'h8000_0000),
    .DEPTH           (4),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ifu_arvalid    (ifu_arvalid),
    .ifu_arready    (ifu_arready),
    .ifu_araddr     (ifu_araddr),
    .ifu_rvalid     (ifu_rvalid),
    .ifu_rready     (ifu_rready),
    .ifu_rdata      (ifu_rdata),
    .ifu_rresp      (ifu_rresp),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_fault     (inst_fault)
  );

  typedef struct {
    logic        rdy;
    logic        exp_arvalid;
    logic [31:0] exp_araddr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t        vecs [10];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] rq [$];
  logic [31:0] aq [$];
  logic [31:0] dpc [$];
  logic [31:0] ddata [$];
  logic        dfault [$];
  logic        hold_r;
  logic [31:0] err_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9bdf;
  endfunction

  function automatic logic [31:0] aq_at(input int i);
    return (i < aq.size()) ? aq[i] : 32'hdead_beef;
  endfunction

  function automatic logic [31:0] dpc_at(input int i);
    return (i < dpc.size()) ? dpc[i] : 32'hdead_beef;
  endfunction

  function automatic logic [31:0] ddata_at(input int i);
    return (i < ddata.size()) ? ddata[i] : 32'hdead_beef;
  endfunction

  function automatic logic dfault_at(input int i);
    return (i < dfault.size()) ? dfault[i] : 1'bx;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_r();
    if (!hold_r && rq.size() > 0) begin
      ifu_rvalid = 1'b1;
      ifu_rdata  = mem_word(rq[0]);
      ifu_rresp  = (rq[0] == err_addr) ? 2'b10 : 2'b00;
    end else begin
      ifu_rvalid = 1'b0;
      ifu_rdata  = '0;
      ifu_rresp  = '0;
    end
  endtask

  // Zero-wait memory: a read accepted at edge N is answered before edge N+1.
  task automatic tick();
    logic        hs, rb;
    logic [31:0] a;
    hs = ifu_arvalid && ifu_arready;
    a  = ifu_araddr;
    rb = ifu_rvalid;
    if (inst_valid && inst_ready) begin
      dpc.push_back(inst_pc);
      ddata.push_back(inst);
      dfault.push_back(inst_fault);
    end
    @(posedge clk);
    #1;
    if (rb) rq.delete(0);
    if (hs) begin
      rq.push_back(a);
      aq.push_back(a);
    end
    drive_r();
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    ifu_arready    = 1'b1;
    inst_ready     = 1'b1;
    hold_r         = 1'b0;
    err_addr       = 32'hffff_fffc;
    rq.delete();
    aq.delete();
    dpc.delete();
    ddata.delete();
    dfault.delete();
    drive_r();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_arvalid"},    ifu_arvalid, 1'b0);
    chk({tag, "_araddr"},     ifu_araddr,  32'h8000_0000);
    chk({tag, "_rready"},     ifu_rready,  1'b1);
    chk({tag, "_inst_valid"}, inst_valid,  1'b0);
    chk({tag, "_inst"},       inst,        32'h0);
    chk({tag, "_inst_pc"},    inst_pc,     32'h0);
    chk({tag, "_inst_fault"}, inst_fault,  1'b0);
  endtask

  always @(posedge clk) begin
    if (!rst && ifu_rvalid) assert (rq.size() > 0) else $error("R beat with no outstanding read");
  end

  initial begin
    for (int k = 0; k < 8; k++) begin
      vecs[k] = '{1'b1, 1'b1, 32'h8000_0000 + 32'(4 * k), (k >= 2), 32'h8000_0000 + 32'(4 * (k - 2))};
    end
    vecs[8] = '{1'b0, 1'b1, 32'h8000_0020, 1'b1, 32'h8000_0014};
    vecs[9] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h8000_0014};

    // Stream from reset, ending with a short consumer stall.
    do_reset();
    chk_reset_outputs("reset");
    for (int k = 0; k < 10; k++) begin
      inst_ready = vecs[k].rdy;
      tick();
      chk($sformatf("v%0d_arvalid", k), ifu_arvalid, vecs[k].exp_arvalid);
      if (vecs[k].exp_arvalid) chk($sformatf("v%0d_araddr", k), ifu_araddr, vecs[k].exp_araddr);
      chk($sformatf("v%0d_inst_valid", k), inst_valid, vecs[k].exp_valid);
      if (vecs[k].exp_valid) begin
        chk($sformatf("v%0d_inst_pc", k), inst_pc, vecs[k].exp_pc);
        chk($sformatf("v%0d_inst", k), inst, mem_word(vecs[k].exp_pc));
        chk($sformatf("v%0d_fault", k), inst_fault, 1'b0);
      end
    end

    // Backpressure fills the buffer, then draining resumes issue.
    do_reset();
    inst_ready = 1'b0;
    repeat (20) tick();
    chk("bp_ar_count", 32'(aq.size()), 32'd4);
    chk("bp_arvalid", ifu_arvalid, 1'b0);
    chk("bp_head_pc", inst_pc, 32'h8000_0000);
    inst_ready = 1'b1;
    repeat (12) tick();
    for (int i = 0; i < 4; i++) chk($sformatf("bp_drain_pc%0d", i), dpc_at(i), 32'h8000_0000 + 32'(4 * i));
    chk("bp_reissue", 32'(aq.size() > 4), 32'd1);

    // Redirect with two reads in flight.
    do_reset();
    hold_r = 1'b1;
    drive_r();
    repeat (5) tick();
    chk("rd_inflight_ars", 32'(aq.size()), 32'd2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_1002;
    tick();
    redirect_valid = 1'b0;
    hold_r         = 1'b0;
    drive_r();
    chk("rd_flushed", inst_valid, 1'b0);
    repeat (15) tick();
    chk("rd_next_ar", aq_at(2), 32'h8000_1000);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rd_pc%0d", i), dpc_at(i), 32'h8000_1000 + 32'(4 * i));
      chk($sformatf("rd_data%0d", i), ddata_at(i), mem_word(32'h8000_1000 + 32'(4 * i)));
    end

    // Redirect while an AR is pending and arready stays low.
    do_reset();
    ifu_arready = 1'b0;
    tick();
    chk("pend_arvalid", ifu_arvalid, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_1000;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("pend_hold_addr%0d", i), ifu_araddr, 32'h8000_0000);
      chk($sformatf("pend_hold_valid%0d", i), ifu_arvalid, 1'b1);
      tick();
    end
    chk("pend_hold_addr2", ifu_araddr, 32'h8000_0000);
    ifu_arready = 1'b1;
    repeat (15) tick();
    chk("pend_stale_ar", aq_at(0), 32'h8000_0000);
    chk("pend_new_ar", aq_at(1), 32'h8000_1000);
    chk("pend_first_pc", dpc_at(0), 32'h8000_1000);

    // Bus error halts issue until a redirect.
    do_reset();
    err_addr = 32'h8000_0008;
    repeat (15) tick();
    chk("err_ar_count", 32'(aq.size()), 32'd4);
    chk("err_arvalid", ifu_arvalid, 1'b0);
    chk("err_delivered", 32'(dpc.size()), 32'd4);
    chk("err_ok_fault", dfault_at(1), 1'b0);
    chk("err_pc", dpc_at(2), 32'h8000_0008);
    chk("err_fault", dfault_at(2), 1'b1);
    chk("err_tail_pc", dpc_at(3), 32'h8000_000c);
    chk("err_tail_fault", dfault_at(3), 1'b0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    tick();
    redirect_valid = 1'b0;
    repeat (6) tick();
    chk("err_resume_ar", aq_at(4), 32'h8000_0100);
    chk("err_resume_pc", dpc_at(4), 32'h8000_0100);
    chk("err_resume_fault", dfault_at(4), 1'b0);

    // Asynchronous reset in the middle of a burst.
    do_reset();
    repeat (6) tick();
    chk("ar_mid_valid", inst_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("async");
    do_reset();
    repeat (6) tick();
    chk("ar_restart_ar", aq_at(0), 32'h8000_0000);
    chk("ar_restart_pc", dpc_at(0), 32'h8000_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
